spi_frm_seq: RTL and testbench
==============================

Name: spi_frm_seq

Overview:
- Frame sequencer in the SPI serial-clock domain. It sits in front of the SPI slave register datapath.
- Counts SCLK edges inside each CSB-low window and splits the stream into 24-bit cmd/data/crc frames, including back-to-back burst frames.
- Hands each completed frame to the i_clk domain through a toggle handshake.
- Decides, frame by frame, which source is shifted out on MISO: register response, status word, or echo of the last received frame.

Parameters:
FRM_BIT_NUM, 24, bits per frame (CMD_W+DATA_W+CRC_W)
CMD_W, 8, command field width
DATA_W, 8, data field width
CRC_W, 8, crc field width
MAX_FRM_NUM, 4, max frames captured per CSB window
CNT_W, $clog2(FRM_BIT_NUM), bit counter width

Ports:
i_spi_sclk  in  1  SPI serial clock; posedge samples MOSI, negedge drives MISO
i_rst_n  in  1  async active-low reset
i_spi_csb  in  1  chip select, low active; high = async window clear
i_spi_mosi  in  1  serial data in, MSB first
i_slv_en  in  1  slave enable, quasi-static
i_rsp_tgl  in  1  response-posted toggle from i_clk domain
i_rsp_frm  in  FRM_BIT_NUM  response frame; stable whenever i_rsp_tgl differs from o_rsp_ack_tgl
i_sts_frm  in  FRM_BIT_NUM  status frame, quasi-static
o_rx_frm  out  FRM_BIT_NUM  last captured frame
o_rx_frm_tgl  out  1  toggles once per captured frame
o_rsp_ack_tgl  out  1  equals i_rsp_tgl once that response is loaded
o_frm_idx  out  $clog2(MAX_FRM_NUM+1)  frames completed in current window
o_phase  out  2  0=CMD, 1=DATA, 2=CRC
o_miso_src  out  2  0=NONE, 1=ECHO, 2=RSP, 3=STS
o_spi_miso  out  1  serial data out
o_frm_len_err_tgl  out  1  toggles per truncated window
o_drop_tgl  out  1  toggles per dropped frame

Behaviour:
- Clock is i_spi_sclk; reset is i_rst_n, asynchronous, active-low.
- i_rst_n low clears every register and output to 0.
- i_spi_csb high asynchronously clears the window state only: bit_cnt, rx shift register, tx_sr, o_frm_idx, o_miso_src, o_spi_miso, win_act.
- The following registers are reset by i_rst_n only and survive CSB:
  - toggles and synchronisers
  - o_rx_frm
  - frm_open
- bit_cnt counts bits received in the current frame, 0..FRM_BIT_NUM-1. It increments on each posedge with CSB low and wraps 23->0.
- rx shift: rx_sr <= {rx_sr[22:0], mosi} on each posedge.
- o_phase decode:
  - CMD when bit_cnt < CMD_W
  - DATA when bit_cnt < CMD_W+DATA_W
  - CRC otherwise
- Frame boundary is the posedge with bit_cnt==23. At that edge:
  - Capture candidate = {rx_sr[22:0], mosi}.
  - If i_slv_en=1 and o_frm_idx < MAX_FRM_NUM: o_rx_frm <= candidate and o_rx_frm_tgl flips.
  - If i_slv_en=1 and o_frm_idx == MAX_FRM_NUM: the frame is dropped and o_drop_tgl flips.
  - If i_slv_en=0: no capture and no drop toggle.
  - o_frm_idx increments, saturating at MAX_FRM_NUM.
  - tx_sr loads per the priority below.
- tx_sr load priority, evaluated at the frame boundary:
  1. i_slv_en=0 -> i_sts_frm, src=STS.
  2. Else rsp_pend -> i_rsp_frm, src=RSP, o_rsp_ack_tgl <= rsp_tgl_s.
  3. Else -> candidate, src=ECHO.
- Response handshake:
  - i_rsp_tgl goes through a 2-flop synchroniser on posedge; the result is rsp_tgl_s.
  - rsp_pend = (rsp_tgl_s != o_rsp_ack_tgl).
  - A response posted fewer than 3 posedges before a boundary is deferred to the next boundary.
  - An unconsumed response stays pending across CSB windows.
- MISO:
  - On negedge, o_spi_miso <= tx_sr[FRM_BIT_NUM-1-bit_cnt]; tx_sr changes only at boundaries.
  - Frame 0 of every window shifts out zeros, because tx_sr is CSB-cleared.
  - Frame k+1 carries the content selected at the end of frame k.
- Truncation detect:
  - frm_open is set on any posedge leaving bit_cnt != 0 and cleared at the boundary.
  - win_act is CSB-cleared and set on the first posedge of a window.
  - On a posedge with win_act=0 and frm_open=1, o_frm_len_err_tgl flips and frm_open clears. The report therefore lands one window late.
- Reset mid-frame: all state clears. The next window starts at bit_cnt=0 with no error report.

Test Plan:
1. Single window, MOSI 24'h853C5A, no response posted -> o_rx_frm=24'h853C5A, o_rx_frm_tgl flips once, o_frm_idx=1, MISO all 0.
2. Two-frame burst; i_rsp_frm=24'hA55A0F and i_rsp_tgl flipped at bit 5 of frame 0 -> frame 1 MISO shifts A55A0F MSB-first, o_miso_src=2, o_rsp_ack_tgl == i_rsp_tgl, o_rx_frm_tgl flips twice.
3. Two-frame burst, no response, frame 0 = 24'h0123C7 -> frame 1 MISO = 24'h0123C7, o_miso_src=1.
4. i_slv_en=0, i_sts_frm=24'h00FF81, two frames -> no o_rx_frm_tgl activity, frame 1 MISO = 24'h00FF81, o_miso_src=3.
5. 13 bits then CSB high, then a full frame 24'h112233 -> o_frm_len_err_tgl flips at the first posedge of window 2, o_rx_frm=24'h112233.
6. Five frames in one window with MAX_FRM_NUM=4 -> four rx toggles, one o_drop_tgl flip, o_frm_idx=4; then i_rst_n pulsed mid-frame -> all outputs 0.

Source files
------------

// File: rtl/spi_frm_seq.sv
// SPI-clock-domain frame sequencer: splits each CSB-low window into fixed-size frames,
// hands captured frames to the core through toggles and selects the MISO source per frame.
module spi_frm_seq #(
    parameter int CMD_W       = 8,
    parameter int DATA_W      = 8,
    parameter int CRC_W       = 8,
    parameter int FRM_BIT_NUM = CMD_W + DATA_W + CRC_W,
    parameter int MAX_FRM_NUM = 4,
    parameter int CNT_W       = $clog2(FRM_BIT_NUM),
    parameter int IDX_W       = $clog2(MAX_FRM_NUM + 1)
) (
    input  logic                   i_spi_sclk,
    input  logic                   i_rst_n,
    input  logic                   i_spi_csb,
    input  logic                   i_spi_mosi,
    input  logic                   i_slv_en,
    input  logic                   i_rsp_tgl,
    input  logic [FRM_BIT_NUM-1:0] i_rsp_frm,
    input  logic [FRM_BIT_NUM-1:0] i_sts_frm,
    output logic [FRM_BIT_NUM-1:0] o_rx_frm,
    output logic                   o_rx_frm_tgl,
    output logic                   o_rsp_ack_tgl,
    output logic [IDX_W-1:0]       o_frm_idx,
    output logic [1:0]             o_phase,
    output logic [1:0]             o_miso_src,
    output logic                   o_spi_miso,
    output logic                   o_frm_len_err_tgl,
    output logic                   o_drop_tgl
);

    typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_ECHO = 2'd1, SRC_RSP = 2'd2, SRC_STS = 2'd3} miso_src_e;
    typedef enum logic [1:0] {PH_CMD = 2'd0, PH_DATA = 2'd1, PH_CRC = 2'd2} phase_e;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRM_BIT_NUM - 1);
    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(MAX_FRM_NUM);

    // Window state is cleared by either reset or CSB deassertion.
    logic win_clr_n;
    assign win_clr_n = i_rst_n & ~i_spi_csb;

    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [FRM_BIT_NUM-2:0] rx_sr_reg;
    logic [FRM_BIT_NUM-1:0] tx_sr_reg;
    logic [IDX_W-1:0]       frm_idx_reg;
    miso_src_e              miso_src_reg;
    logic                   win_act_reg;
    logic                   miso_reg;

    logic                   rsp_meta_reg;
    logic                   rsp_tgl_s_reg;
    logic                   rsp_ack_tgl_reg;
    logic [FRM_BIT_NUM-1:0] rx_frm_reg;
    logic                   rx_frm_tgl_reg;
    logic                   drop_tgl_reg;
    logic                   len_err_tgl_reg;
    logic                   frm_open_reg;

    logic                   frm_end;
    logic                   capture_ok;
    logic                   rsp_pend;
    logic [FRM_BIT_NUM-1:0] cand;
    logic [FRM_BIT_NUM-1:0] tx_next;
    miso_src_e              src_next;
    logic                   rsp_take;
    phase_e                 phase;

    assign frm_end    = (bit_cnt_reg == LAST_BIT);
    assign capture_ok = (frm_idx_reg < MAX_IDX);
    assign rsp_pend   = (rsp_tgl_s_reg != rsp_ack_tgl_reg);
    assign cand       = {rx_sr_reg, i_spi_mosi};

    // Source for the next frame: status when disabled, then a pending response, else echo.
    always_comb begin
        tx_next  = cand;
        src_next = SRC_ECHO;
        rsp_take = 1'b0;
        if (!i_slv_en) begin
            tx_next  = i_sts_frm;
            src_next = SRC_STS;
        end else if (rsp_pend) begin
            tx_next  = i_rsp_frm;
            src_next = SRC_RSP;
            rsp_take = 1'b1;
        end
    end

    always_comb begin
        if (bit_cnt_reg < CNT_W'(CMD_W)) begin
            phase = PH_CMD;
        end else if (bit_cnt_reg < CNT_W'(CMD_W + DATA_W)) begin
            phase = PH_DATA;
        end else begin
            phase = PH_CRC;
        end
    end

    always_ff @(posedge i_spi_sclk or negedge win_clr_n) begin
        if (!win_clr_n) begin
            bit_cnt_reg  <= '0;
            rx_sr_reg    <= '0;
            tx_sr_reg    <= '0;
            frm_idx_reg  <= '0;
            miso_src_reg <= SRC_NONE;
            win_act_reg  <= 1'b0;
        end else begin
            win_act_reg <= 1'b1;
            rx_sr_reg   <= cand[FRM_BIT_NUM-2:0];
            if (frm_end) begin
                bit_cnt_reg  <= '0;
                tx_sr_reg    <= tx_next;
                miso_src_reg <= src_next;
                if (capture_ok) begin
                    frm_idx_reg <= frm_idx_reg + 1'b1;
                end
            end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // State that must survive CSB: handshake toggles, last frame and the open-frame marker.
    always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_meta_reg    <= 1'b0;
            rsp_tgl_s_reg   <= 1'b0;
            rsp_ack_tgl_reg <= 1'b0;
            rx_frm_reg      <= '0;
            rx_frm_tgl_reg  <= 1'b0;
            drop_tgl_reg    <= 1'b0;
            len_err_tgl_reg <= 1'b0;
            frm_open_reg    <= 1'b0;
        end else begin
            rsp_meta_reg  <= i_rsp_tgl;
            rsp_tgl_s_reg <= rsp_meta_reg;
            frm_open_reg  <= !frm_end;
            // A frame still open at the first edge of a new window was cut short.
            if (!win_act_reg && frm_open_reg) begin
                len_err_tgl_reg <= ~len_err_tgl_reg;
            end
            if (frm_end && i_slv_en) begin
                if (capture_ok) begin
                    rx_frm_reg     <= cand;
                    rx_frm_tgl_reg <= ~rx_frm_tgl_reg;
                end else begin
                    drop_tgl_reg <= ~drop_tgl_reg;
                end
            end
            if (frm_end && rsp_take) begin
                rsp_ack_tgl_reg <= rsp_tgl_s_reg;
            end
        end
    end

    always_ff @(negedge i_spi_sclk or negedge win_clr_n) begin
        if (!win_clr_n) begin
            miso_reg <= 1'b0;
        end else begin
            miso_reg <= tx_sr_reg[LAST_BIT - bit_cnt_reg];
        end
    end

    assign o_rx_frm          = rx_frm_reg;
    assign o_rx_frm_tgl      = rx_frm_tgl_reg;
    assign o_rsp_ack_tgl     = rsp_ack_tgl_reg;
    assign o_frm_idx         = frm_idx_reg;
    assign o_phase           = phase;
    assign o_miso_src        = miso_src_reg;
    assign o_spi_miso        = miso_reg;
    assign o_frm_len_err_tgl = len_err_tgl_reg;
    assign o_drop_tgl        = drop_tgl_reg;

endmodule

// File: tb/tb_spi_frm_seq.sv
// Bench for spi_frm_seq: drives SPI windows bit by bit and compares against a
// frame-level model of capture, drop, handshake, MISO source and truncation reporting.
module tb_spi_frm_seq;

    logic        i_spi_sclk;
    logic        i_rst_n;
    logic        i_spi_csb;
    logic        i_spi_mosi;
    logic        i_slv_en;
    logic        i_rsp_tgl;
    logic [23:0] i_rsp_frm;
    logic [23:0] i_sts_frm;
    logic [23:0] o_rx_frm;
    logic        o_rx_frm_tgl;
    logic        o_rsp_ack_tgl;
    logic [2:0]  o_frm_idx;
    logic [1:0]  o_phase;
    logic [1:0]  o_miso_src;
    logic        o_spi_miso;
    logic        o_frm_len_err_tgl;
    logic        o_drop_tgl;

    spi_frm_seq dut (
        .i_spi_sclk        (i_spi_sclk),
        .i_rst_n           (i_rst_n),
        .i_spi_csb         (i_spi_csb),
        .i_spi_mosi        (i_spi_mosi),
        .i_slv_en          (i_slv_en),
        .i_rsp_tgl         (i_rsp_tgl),
        .i_rsp_frm         (i_rsp_frm),
        .i_sts_frm         (i_sts_frm),
        .o_rx_frm          (o_rx_frm),
        .o_rx_frm_tgl      (o_rx_frm_tgl),
        .o_rsp_ack_tgl     (o_rsp_ack_tgl),
        .o_frm_idx         (o_frm_idx),
        .o_phase           (o_phase),
        .o_miso_src        (o_miso_src),
        .o_spi_miso        (o_spi_miso),
        .o_frm_len_err_tgl (o_frm_len_err_tgl),
        .o_drop_tgl        (o_drop_tgl)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference state
    logic [23:0] w_frm [8];
    logic [23:0] m_rx_frm;
    logic        m_rx_tgl;
    logic        m_drop_tgl;
    logic        m_err_tgl;
    logic        m_ack_tgl;
    bit          m_pend;
    bit          m_open;
    logic [23:0] m_rsp_val;

    task automatic model_reset();
        m_rx_frm   = '0;
        m_rx_tgl   = 1'b0;
        m_drop_tgl = 1'b0;
        m_err_tgl  = 1'b0;
        m_ack_tgl  = 1'b0;
        m_pend     = 0;
        m_open     = 0;
        m_rsp_val  = '0;
    endtask

    // One CSB window: nfrm whole frames from w_frm, then trunc_bits of frame nfrm.
    task automatic run_window(input string tag, input int nfrm, input int trunc_bits, input bit en,
                              input int rsp_k, input int rsp_bit, input logic [23:0] rsp_val,
                              input logic [23:0] sts_val);
        logic [23:0] exp_miso;
        logic [23:0] got_miso;
        logic [1:0]  exp_src;
        logic [1:0]  exp_ph;
        int          idx;
        int          nbits;
        bit          first;
        exp_miso  = '0;
        exp_src   = 2'd0;
        idx       = 0;
        first     = 1;
        i_slv_en  = en;
        i_sts_frm = sts_val;
        #5;
        i_spi_csb = 1'b0;
        #5;
        for (int k = 0; k <= nfrm; k++) begin
            nbits = (k < nfrm) ? 24 : trunc_bits;
            if (nbits == 0) break;
            got_miso = '0;
            for (int b = 0; b < nbits; b++) begin
                if (k == rsp_k && b == rsp_bit && !m_pend) begin
                    i_rsp_frm = rsp_val;
                    i_rsp_tgl = ~i_rsp_tgl;
                    m_pend    = 1;
                    m_rsp_val = rsp_val;
                end
                i_spi_mosi = w_frm[k][23-b];
                #4;
                exp_ph = (b < 8) ? 2'd0 : ((b < 16) ? 2'd1 : 2'd2);
                n_checks++;
                if (o_phase !== exp_ph) begin
                    n_errors++;
                    $display("FAIL %s phase frm%0d bit%0d: got %0d, expected %0d", tag, k, b, o_phase, exp_ph);
                end
                got_miso[23-b] = o_spi_miso;
                #1 i_spi_sclk = 1'b1;
                #2;
                if (first) begin
                    first = 0;
                    if (m_open) m_err_tgl = ~m_err_tgl;
                    m_open = 0;
                    n_checks++;
                    if (o_frm_len_err_tgl !== m_err_tgl) begin
                        n_errors++;
                        $display("FAIL %s len_err_tgl at first edge: got %b, expected %b", tag, o_frm_len_err_tgl, m_err_tgl);
                    end
                end
                #3 i_spi_sclk = 1'b0;
            end
            #1;
            if (k < nfrm) begin
                n_checks++;
                if (got_miso !== exp_miso) begin
                    n_errors++;
                    $display("FAIL %s miso frm%0d: got %h, expected %h", tag, k, got_miso, exp_miso);
                end
                // Boundary rules applied to frame k
                if (en) begin
                    if (idx < 4) begin
                        m_rx_frm = w_frm[k];
                        m_rx_tgl = ~m_rx_tgl;
                    end else begin
                        m_drop_tgl = ~m_drop_tgl;
                    end
                end
                if (idx < 4) idx++;
                if (!en) begin
                    exp_miso = sts_val;
                    exp_src  = 2'd3;
                end else if (m_pend) begin
                    exp_miso  = m_rsp_val;
                    exp_src   = 2'd2;
                    m_pend    = 0;
                    m_ack_tgl = i_rsp_tgl;
                end else begin
                    exp_miso = w_frm[k];
                    exp_src  = 2'd1;
                end
                n_checks++;
                if (o_rx_frm !== m_rx_frm) begin
                    n_errors++;
                    $display("FAIL %s rx_frm frm%0d: got %h, expected %h", tag, k, o_rx_frm, m_rx_frm);
                end
                n_checks++;
                if (o_rx_frm_tgl !== m_rx_tgl) begin
                    n_errors++;
                    $display("FAIL %s rx_frm_tgl frm%0d: got %b, expected %b", tag, k, o_rx_frm_tgl, m_rx_tgl);
                end
                n_checks++;
                if (o_drop_tgl !== m_drop_tgl) begin
                    n_errors++;
                    $display("FAIL %s drop_tgl frm%0d: got %b, expected %b", tag, k, o_drop_tgl, m_drop_tgl);
                end
                n_checks++;
                if (o_frm_idx !== 3'(idx)) begin
                    n_errors++;
                    $display("FAIL %s frm_idx frm%0d: got %0d, expected %0d", tag, k, o_frm_idx, idx);
                end
                n_checks++;
                if (o_miso_src !== exp_src) begin
                    n_errors++;
                    $display("FAIL %s miso_src frm%0d: got %0d, expected %0d", tag, k, o_miso_src, exp_src);
                end
                n_checks++;
                if (o_rsp_ack_tgl !== m_ack_tgl) begin
                    n_errors++;
                    $display("FAIL %s rsp_ack_tgl frm%0d: got %b, expected %b", tag, k, o_rsp_ack_tgl, m_ack_tgl);
                end
            end
        end
        m_open = (trunc_bits > 0);
        #4;
        i_spi_csb = 1'b1;
        #5;
        n_checks++;
        if ({o_frm_idx, o_miso_src, o_spi_miso, o_phase} !== 8'h00) begin
            n_errors++;
            $display("FAIL %s csb clear: got idx=%0d src=%0d miso=%b phase=%0d, expected all 0",
                     tag, o_frm_idx, o_miso_src, o_spi_miso, o_phase);
        end
        n_checks++;
        if (o_frm_len_err_tgl !== m_err_tgl) begin
            n_errors++;
            $display("FAIL %s len_err_tgl at window end: got %b, expected %b", tag, o_frm_len_err_tgl, m_err_tgl);
        end
        $display("window %s: frames=%0d trunc=%0d en=%0d rx_frm=%h", tag, nfrm, trunc_bits, en, o_rx_frm);
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({o_rx_frm, o_rx_frm_tgl, o_rsp_ack_tgl, o_frm_idx, o_phase, o_miso_src,
             o_spi_miso, o_frm_len_err_tgl, o_drop_tgl} !== 36'h0) begin
            n_errors++;
            $display("FAIL reset outputs: got rx=%h idx=%0d src=%0d tgls=%b%b%b%b, expected all 0",
                     o_rx_frm, o_frm_idx, o_miso_src, o_rx_frm_tgl, o_rsp_ack_tgl, o_frm_len_err_tgl, o_drop_tgl);
        end
        i_rst_n = 1'b1;
        #5;
        $display("reset: released");
    endtask

    task automatic test_single();
        w_frm[0] = 24'h853C5A;
        run_window("single", 1, 0, 1'b1, -1, 0, 24'h0, 24'h0);
    endtask

    task automatic test_rsp_burst();
        w_frm[0] = 24'h3C1E77;
        w_frm[1] = 24'h9D0042;
        run_window("rsp_burst", 2, 0, 1'b1, 0, 5, 24'hA55A0F, 24'h0);
        n_checks++;
        if (o_rsp_ack_tgl !== i_rsp_tgl) begin
            n_errors++;
            $display("FAIL rsp_burst ack follows rsp: got %b, expected %b", o_rsp_ack_tgl, i_rsp_tgl);
        end
    endtask

    task automatic test_echo();
        w_frm[0] = 24'h0123C7;
        w_frm[1] = 24'h5E6F70;
        run_window("echo", 2, 0, 1'b1, -1, 0, 24'h0, 24'h0);
    endtask

    task automatic test_status();
        w_frm[0] = 24'hCAFE01;
        w_frm[1] = 24'h123456;
        run_window("status", 2, 0, 1'b0, -1, 0, 24'h0, 24'h00FF81);
    endtask

    task automatic test_truncation();
        w_frm[0] = 24'hF0F0F0;
        run_window("trunc", 0, 13, 1'b1, -1, 0, 24'h0, 24'h0);
        w_frm[0] = 24'h112233;
        run_window("after_trunc", 1, 0, 1'b1, -1, 0, 24'h0, 24'h0);
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) w_frm[k] = 24'($urandom);
        run_window("overflow", 5, 0, 1'b1, -1, 0, 24'h0, 24'h0);
    endtask

    task automatic test_reset_mid_frame();
        #5;
        i_spi_csb = 1'b0;
        #5;
        for (int b = 0; b < 10; b++) begin
            i_spi_mosi = 1'($urandom);
            #5 i_spi_sclk = 1'b1;
            #5 i_spi_sclk = 1'b0;
        end
        #2;
        i_rst_n   = 1'b0;
        i_rsp_tgl = 1'b0;
        #2;
        n_checks++;
        if ({o_rx_frm, o_rx_frm_tgl, o_rsp_ack_tgl, o_frm_idx, o_phase, o_miso_src,
             o_spi_miso, o_frm_len_err_tgl, o_drop_tgl} !== 36'h0) begin
            n_errors++;
            $display("FAIL mid_reset outputs: got rx=%h idx=%0d src=%0d tgls=%b%b%b%b, expected all 0",
                     o_rx_frm, o_frm_idx, o_miso_src, o_rx_frm_tgl, o_rsp_ack_tgl, o_frm_len_err_tgl, o_drop_tgl);
        end
        i_spi_csb = 1'b1;
        #5;
        i_rst_n = 1'b1;
        model_reset();
        $display("mid_reset: outputs cleared");
        w_frm[0] = 24'h445566;
        run_window("post_reset", 1, 0, 1'b1, -1, 0, 24'h0, 24'h0);
    endtask

    task automatic test_random();
        int nfrm;
        int trunc;
        int rk;
        bit en;
        for (int it = 0; it < 25; it++) begin
            nfrm  = int'($urandom_range(1, 6));
            trunc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 22)) : 0;
            en    = ($urandom_range(0, 4) != 0);
            rk    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nfrm - 1)) : -1;
            for (int k = 0; k < 8; k++) w_frm[k] = 24'($urandom);
            run_window($sformatf("rand%0d", it), nfrm, trunc, en, rk, int'($urandom_range(0, 18)),
                       24'($urandom), 24'($urandom));
        end
    endtask

    initial begin
        i_spi_sclk = 1'b0;
        i_rst_n    = 1'b0;
        i_spi_csb  = 1'b1;
        i_spi_mosi = 1'b0;
        i_slv_en   = 1'b1;
        i_rsp_tgl  = 1'b0;
        i_rsp_frm  = '0;
        i_sts_frm  = '0;
        model_reset();
        test_reset();
        test_single();
        test_rsp_burst();
        test_echo();
        test_status();
        test_truncation();
        test_overflow();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
